pe_stream_driver: RTL and testbench
===================================

Name: pe_stream_driver

Overview:
- Initiator side of the PE operand/result interface.
- Accepts a stream of (activation, weight) pairs over valid/ready and clears the PE accumulator before each vector.
- Drives the pairs into one MAC PE, zero-pads through the PE pipeline, then captures the dot product.
- Presents the captured result on a valid/ready output with the pair count. Sits between the operand buffers and a single PE.

Parameters:
BW, 8, operand width; PE result width is 2*BW
PE_LATENCY, 3, PE cycles from operand sample to stable o_output (input reg, acc reg, output reg)
CNT_W, 16, width of pair counter

Ports:
i_clock  in  1  clock
i_reset  in  1  synchronous active-high reset
s_valid  in  1  operand pair valid
s_ready  out  1  driver accepts pair
s_activation  in  BW  activation operand
s_weight  in  BW  weight operand
s_last  in  1  pair is last of vector
m_valid  out  1  result valid
m_ready  in  1  downstream accepts result
m_result  out  2*BW  dot product, mod 2^(2*BW)
m_count  out  CNT_W  pairs in vector, saturating
o_pe_activation  out  BW  to PE i_activation, registered
o_pe_weight  out  BW  to PE i_weight, registered
o_pe_clear  out  1  to PE i_reset, registered
i_pe_output  in  2*BW  from PE o_output

Behaviour:
- Interface: one clock i_clock; i_reset synchronous, active-high.
- Reset values: state IDLE; s_ready=0; m_valid=0; m_result=0; m_count=0; o_pe_activation=0; o_pe_weight=0; o_pe_clear=1; drain counter=0.
- o_pe_clear is 1 while in reset and in CLEAR, else 0. Reset mid-operation aborts the vector, and the PE is cleared again via CLEAR before the next vector.
- IDLE: s_ready=0, operands 0. When s_valid=1 -> CLEAR. The pair is not consumed in this cycle.
- CLEAR (exactly 1 cycle): o_pe_clear=1, operands 0, count<=0 -> STREAM.
- STREAM: s_ready=1.
  - On handshake (s_valid&s_ready): o_pe_activation/o_pe_weight <= s_activation/s_weight next cycle; count<=count+1, saturating at 2^CNT_W-1.
  - On no handshake (bubble): operands <= 0, so 0*0 leaves the accumulator unchanged.
  - Handshake with s_last=1 -> DRAIN with drain counter <= PE_LATENCY.
- DRAIN: s_ready=0, operands 0, counter decrements each cycle.
  - At the edge where counter==0: m_result <= i_pe_output, m_count <= count, m_valid <= 1 -> HOLD.
  - Net effect: result captured PE_LATENCY+1 edges after the last-pair handshake edge.
- HOLD: m_valid=1, m_result and m_count stable, s_ready=0. On m_ready=1 -> IDLE and m_valid <= 0 next cycle.
- A new vector starts only from IDLE, so the minimum gap from result acceptance to the next CLEAR is 1 cycle.
- m_ready is ignored unless m_valid=1. s_last is ignored without a handshake.
- Arithmetic: m_result is the PE's 2*BW-bit wrapped sum; the driver does no overflow detection.
- A single-pair vector (first pair has s_last=1) is legal: STREAM handshake goes directly to DRAIN.

Decomposition:
- Package pe_pkg: state enum (IDLE, CLEAR, STREAM, DRAIN, HOLD), default BW, PE_LATENCY localparam.
- Single module, no sub-modules. The bench instantiates the existing PE as the load and connects o_pe_* and i_pe_output to it.

Test Plan:
1. Pairs (3,4),(5,6),(7,8) back-to-back, m_ready=1 -> m_result=98, m_count=3; m_valid 1 cycle; o_pe_clear pulsed exactly once before the first pair.
2. Same pairs with 2-cycle s_valid gaps between them -> m_result=98, m_count=3; o_pe_* = 0 during gaps.
3. Single pair (10,20) with s_last, m_ready held 0 for 5 cycles -> m_valid stays 1, m_result=200, m_count=1; s_ready=0 throughout HOLD; IDLE after m_ready.
4. Two pairs (255,255),(255,255) -> m_result=64514 (130050 mod 65536), m_count=2.
5. i_reset asserted mid-STREAM after 2 pairs, then vector (2,3),(4,5) -> no m_valid for the aborted vector; o_pe_clear=1 during reset; second result=26, m_count=2.
6. Two vectors back-to-back, (1,1)x4 then (2,2)x2 -> results 4 then 8 (no carry-over); CLEAR cycle observed between them.

Source files
------------

// File: rtl/pe_pkg.sv
// Shared types and defaults for the PE stream driver.
// Holds the controller state encoding and the default datapath geometry.
package pe_pkg;

  localparam int BW_DEF         = 8;
  localparam int PE_LATENCY_DEF = 3;
  localparam int CNT_W_DEF      = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLEAR  = 3'd1,
    ST_STREAM = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_HOLD   = 3'd4
  } state_t;

  // Drain counter width; must hold PE_LATENCY and never collapse to zero bits.
  function automatic int drain_w(input int latency);
    int w;
    w = 1;
    while ((1 << w) <= latency) w++;
    return w;
  endfunction

endpackage

// File: rtl/pe_stream_driver.sv
// Initiator for a single MAC PE: clears it, streams operand pairs, drains the
// PE pipeline and presents the captured dot product on a valid/ready port.
//
// state  | meaning
// IDLE   | waiting for the first pair of a vector; nothing consumed
// CLEAR  | one cycle with the PE held in clear, pair counter zeroed
// STREAM | accepting pairs; bubbles feed 0*0 into the PE
// DRAIN  | zero-padding while the last product walks through the PE
// HOLD   | result and pair count presented until m_ready
module pe_stream_driver
  import pe_pkg::*;
#(
  parameter int BW         = BW_DEF,
  parameter int PE_LATENCY = PE_LATENCY_DEF,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [BW-1:0]     s_activation,
  input  logic [BW-1:0]     s_weight,
  input  logic              s_last,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [2*BW-1:0]   m_result,
  output logic [CNT_W-1:0]  m_count,
  output logic [BW-1:0]     o_pe_activation,
  output logic [BW-1:0]     o_pe_weight,
  output logic              o_pe_clear,
  input  logic [2*BW-1:0]   i_pe_output
);

  localparam int DW = drain_w(PE_LATENCY);

  state_t              r_state;
  logic                r_s_ready;
  logic                r_m_valid;
  logic [2*BW-1:0]     r_m_result;
  logic [CNT_W-1:0]    r_m_count;
  logic [CNT_W-1:0]    r_count;
  logic [DW-1:0]       r_drain;
  logic [BW-1:0]       r_pe_act;
  logic [BW-1:0]       r_pe_wt;
  logic                r_pe_clear;

  logic                w_hs;

  assign w_hs = s_valid & r_s_ready;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state    <= ST_IDLE;
      r_s_ready  <= 1'b0;
      r_m_valid  <= 1'b0;
      r_m_result <= '0;
      r_m_count  <= '0;
      r_count    <= '0;
      r_drain    <= '0;
      r_pe_act   <= '0;
      r_pe_wt    <= '0;
      r_pe_clear <= 1'b1;
    end else begin
      // Operands default to zero so any non-handshake cycle is a PE no-op.
      r_pe_act   <= '0;
      r_pe_wt    <= '0;
      r_pe_clear <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (s_valid) begin
            r_state    <= ST_CLEAR;
            r_pe_clear <= 1'b1;
          end
        end
        ST_CLEAR: begin
          r_count   <= '0;
          r_s_ready <= 1'b1;
          r_state   <= ST_STREAM;
        end
        ST_STREAM: begin
          if (w_hs) begin
            r_pe_act <= s_activation;
            r_pe_wt  <= s_weight;
            if (r_count != {CNT_W{1'b1}}) r_count <= r_count + 1'b1;
            if (s_last) begin
              r_s_ready <= 1'b0;
              r_drain   <= DW'(PE_LATENCY);
              r_state   <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          // Counting down to zero adds one edge on top of PE_LATENCY, which
          // covers the driver's own operand register in front of the PE.
          if (r_drain == '0) begin
            r_m_result <= i_pe_output;
            r_m_count  <= r_count;
            r_m_valid  <= 1'b1;
            r_state    <= ST_HOLD;
          end else begin
            r_drain <= r_drain - 1'b1;
          end
        end
        ST_HOLD: begin
          if (m_ready) begin
            r_m_valid <= 1'b0;
            r_state   <= ST_IDLE;
          end
        end
        default: begin
          r_state   <= ST_IDLE;
          r_s_ready <= 1'b0;
          r_m_valid <= 1'b0;
        end
      endcase
    end
  end

  assign s_ready         = r_s_ready;
  assign m_valid         = r_m_valid;
  assign m_result        = r_m_result;
  assign m_count         = r_m_count;
  assign o_pe_activation = r_pe_act;
  assign o_pe_weight     = r_pe_wt;
  assign o_pe_clear      = r_pe_clear;

endmodule

// File: tb/tb_pe_stream_driver.sv
// Bench for pe_stream_driver with a behavioural 3-stage MAC PE as its load.
// Expected results are sums of products computed per vector from the stimulus.
module tb_pe_stream_driver;

  localparam int BW    = 8;
  localparam int RW    = 2 * BW;
  localparam int CNT_W = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              s_valid = 1'b0;
  logic              s_ready;
  logic [BW-1:0]     s_activation = '0;
  logic [BW-1:0]     s_weight = '0;
  logic              s_last = 1'b0;
  logic              m_valid;
  logic              m_ready = 1'b1;
  logic [RW-1:0]     m_result;
  logic [CNT_W-1:0]  m_count;
  logic [BW-1:0]     o_pe_activation;
  logic [BW-1:0]     o_pe_weight;
  logic              o_pe_clear;
  logic [RW-1:0]     pe_out;

  always #5 clk = ~clk;

  pe_stream_driver dut (
    .i_clock(clk), .i_reset(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_activation(s_activation),
    .s_weight(s_weight), .s_last(s_last),
    .m_valid(m_valid), .m_ready(m_ready), .m_result(m_result), .m_count(m_count),
    .o_pe_activation(o_pe_activation), .o_pe_weight(o_pe_weight),
    .o_pe_clear(o_pe_clear), .i_pe_output(pe_out)
  );

  // PE load: input register, accumulator, output register.
  logic [RW-1:0] pe_a_q, pe_w_q, pe_acc;
  always @(posedge clk) begin
    if (o_pe_clear) begin
      pe_a_q <= '0; pe_w_q <= '0; pe_acc <= '0; pe_out <= '0;
    end else begin
      pe_a_q <= {{BW{1'b0}}, o_pe_activation};
      pe_w_q <= {{BW{1'b0}}, o_pe_weight};
      pe_acc <= pe_acc + pe_a_q * pe_w_q;
      pe_out <= pe_acc;
    end
  end

  int n_checks = 0;
  int n_fail   = 0;
  int rdy_mode = 0;
  int clr_cycles = 0;
  int va[$];
  int wa[$];
  int exp_res_q[$];
  int exp_cnt_q[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    case (rdy_mode)
      0:       m_ready = 1'b1;
      1:       m_ready = 1'($urandom_range(0, 1));
      default: m_ready = 1'b0;
    endcase
    if (!rst && m_valid) begin
      chk("hold_s_ready", s_ready, 0);
      if (m_ready) begin
        if (exp_res_q.size() == 0) chk("spurious_result", 1, 0);
        else begin
          chk("m_result", m_result, exp_res_q.pop_front());
          chk("m_count", m_count, exp_cnt_q.pop_front());
        end
      end
    end
    if (!rst && o_pe_clear) clr_cycles++;
  end

  task automatic drive_pair(input int a, input int w, input bit last, input int gap);
    int t;
    s_valid = 1'b1;
    s_activation = BW'(a);
    s_weight = BW'(w);
    s_last = last;
    t = 0;
    while (!s_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("hs_ready", s_ready, 1);
    @(negedge clk);
    chk("op_act", o_pe_activation, a);
    chk("op_wt", o_pe_weight, w);
    // Junk on the bus while invalid, including s_last, must be ignored.
    s_valid = 1'b0;
    s_activation = BW'($urandom);
    s_weight = BW'($urandom);
    s_last = 1'($urandom_range(0, 1));
    repeat (gap) begin
      @(negedge clk);
      chk("gap_act", o_pe_activation, 0);
      chk("gap_wt", o_pe_weight, 0);
    end
  endtask

  task automatic drive_vec(input int gap);
    longint sum;
    sum = 0;
    foreach (va[i]) sum += longint'(va[i]) * longint'(wa[i]);
    exp_res_q.push_back(int'(sum % 65536));
    exp_cnt_q.push_back(va.size() > 65535 ? 65535 : va.size());
    foreach (va[i]) drive_pair(va[i], wa[i], i == va.size() - 1, (i == va.size() - 1) ? 0 : gap);
    s_last = 1'b0;
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while ((exp_res_q.size() != 0 || m_valid) && t < 500) begin
      @(negedge clk);
      t++;
    end
    chk("done_pending", exp_res_q.size(), 0);
    @(negedge clk);
  endtask

  task automatic set_vec(input int a0, input int w0, input int n);
    va.delete(); wa.delete();
    for (int i = 0; i < n; i++) begin va.push_back(a0); wa.push_back(w0); end
  endtask

  initial begin
    int t;
    repeat (3) @(negedge clk);
    chk("rst_s_ready", s_ready, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_result", m_result, 0);
    chk("rst_m_count", m_count, 0);
    chk("rst_pe_act", o_pe_activation, 0);
    chk("rst_pe_wt", o_pe_weight, 0);
    chk("rst_pe_clear", o_pe_clear, 1);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Back-to-back pairs, latency and one-cycle result
    clr_cycles = 0;
    va = '{3, 5, 7}; wa = '{4, 6, 8};
    drive_vec(0);
    repeat (3) begin
      @(negedge clk);
      chk("t1_lat_lo", m_valid, 0);
    end
    @(negedge clk);
    chk("t1_lat_hi", m_valid, 1);
    chk("t1_result", m_result, 98);
    @(negedge clk);
    chk("t1_valid_pulse", m_valid, 0);
    chk("t1_clear_cnt", clr_cycles, 1);
    wait_done();

    // Gaps between pairs
    va = '{3, 5, 7}; wa = '{4, 6, 8};
    drive_vec(2);
    wait_done();

    // Single pair held in HOLD
    rdy_mode = 2;
    va = '{10}; wa = '{20};
    drive_vec(0);
    t = 0;
    while (!m_valid && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("t3_valid", m_valid, 1);
    repeat (5) begin
      @(negedge clk);
      chk("t3_hold_valid", m_valid, 1);
      chk("t3_hold_result", m_result, 200);
      chk("t3_hold_count", m_count, 1);
      chk("t3_hold_s_ready", s_ready, 0);
    end
    rdy_mode = 0;
    wait_done();
    chk("t3_released", m_valid, 0);

    // Wraparound
    va = '{255, 255}; wa = '{255, 255};
    drive_vec(0);
    wait_done();

    // Reset mid-stream
    drive_pair(9, 9, 1'b0, 0);
    drive_pair(9, 9, 1'b0, 0);
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("t5_rst_clear", o_pe_clear, 1);
      chk("t5_rst_s_ready", s_ready, 0);
      chk("t5_rst_m_valid", m_valid, 0);
    end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    clr_cycles = 0;
    va = '{2, 4}; wa = '{3, 5};
    drive_vec(1);
    wait_done();
    chk("t5_clear_cnt", clr_cycles, 1);

    // Two vectors back-to-back, no carry-over
    clr_cycles = 0;
    set_vec(1, 1, 4);
    drive_vec(0);
    set_vec(2, 2, 2);
    drive_vec(0);
    wait_done();
    chk("t6_clear_cnt", clr_cycles, 2);

    // Random vectors with random gaps and backpressure
    for (int v = 0; v < 25; v++) begin
      int n;
      rdy_mode = int'($urandom_range(0, 1));
      n = int'($urandom_range(1, 8));
      va.delete(); wa.delete();
      for (int i = 0; i < n; i++) begin
        va.push_back(int'($urandom_range(0, 255)));
        wa.push_back(int'($urandom_range(0, 255)));
      end
      drive_vec(int'($urandom_range(0, 2)));
    end
    rdy_mode = 0;
    wait_done();
    chk("final_queue", exp_cnt_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
